// File: rtl/led_seq_pkg.sv
// led_seq_pkg
//   Shared types and helpers for the LED display sequencer.
//   - state_t   : sequencer FSM states (IDLE, SHOW, ADVANCE)
//   - NIBBLE_W  : width of one displayable source
//   - next_idx  : increment an index with wrap-around modulo n
package led_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW    = 2'd1,
    ADVANCE = 2'd2
  } state_t;

  // Returns idx+1, wrapping to 0 after n-1.
  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
//   Synchronises a raw active-low push-button, debounces it and emits a
//   one-cycle pulse on each accepted press (falling edge of the debounced level).
//   Ports:
//     clk          in   system clock
//     rst_n        in   asynchronous active-low reset
//     btn_n        in   raw button, active-low, asynchronous to clk
//     press_pulse  out  one-cycle pulse per accepted press
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  // Synchroniser and level both reset to 1 so a released button does not
  // look like a press when reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
          // Accepting a low level means the debounced level falls: a press.
          press_reg <= ~sync2_reg;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        // Any return to the debounced level restarts the stability window.
        cnt_reg <= '0;
      end
    end
  end

  assign press_pulse = press_reg;

endmodule

// File: rtl/led_display_sequencer.sv
// led_display_sequencer
//   Time-shares a 4-bit LED bank between NUM_CH nibble sources. The displayed
//   channel advances on a debounced button press or an auto-scroll dwell
//   timer; invalid channels are skipped. An optional blink overlay blanks the
//   display while err_flag is set.
//   Ports:
//     clk         in   system clock
//     rst_n       in   asynchronous active-low reset
//     ch_data     in   packed sources, channel i at [4i+3:4i]
//     ch_valid    in   per-channel displayable flag
//     btn_next_n  in   raw push-button, active-low
//     mode_auto   in   1 = auto-scroll enabled
//     err_flag    in   1 = blink the displayed value
//     disp_value  out  nibble to LED decoder
//     sel         out  index of displayed channel
//     busy        out  high while searching for the next valid channel
module led_display_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DWELL_CYCLES    = 27_000_000,
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int BLINK_CYCLES    = 6_750_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NIBBLE_W*NUM_CH-1:0] ch_data,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic                       btn_next_n,
  input  logic                       mode_auto,
  input  logic                       err_flag,
  output logic [NIBBLE_W-1:0]        disp_value,
  output logic [$clog2(NUM_CH)-1:0]  sel,
  output logic                       busy
);

  localparam int SW = $clog2(NUM_CH);
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [SW-1:0] TRIES_LAST = SW'(NUM_CH - 1);

  logic [NIBBLE_W-1:0] nib [NUM_CH];

  state_t              state_reg;
  logic [SW-1:0]       sel_reg;
  logic [SW-1:0]       cand_reg;
  logic [SW-1:0]       tries_reg;
  logic [DW-1:0]       dwell_reg;
  logic [NIBBLE_W-1:0] disp_reg;
  logic                busy_reg;
  logic [BW-1:0]       blink_cnt_reg;
  logic                phase_reg;
  logic                press_pulse;
  logic                adv_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_nib
      assign nib[gi] = ch_data[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n      (btn_next_n),
    .press_pulse(press_pulse)
  );

  // Press and dwell expiry are OR-ed into a single request, so a coincident
  // pair produces one advance only.
  assign adv_req = press_pulse | (mode_auto & (dwell_reg == DWELL_LAST));

  // Blink phase generator: idle (count 0, phase 0) whenever err_flag is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (!err_flag) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_reg <= '0;
      phase_reg     <= ~phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BW'(1);
    end
  end

  // Sequencer FSM. tries_reg counts candidates already rejected so the
  // search gives up after exactly NUM_CH tests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      cand_reg  <= '0;
      tries_reg <= '0;
      dwell_reg <= '0;
      disp_reg  <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          disp_reg  <= '0;
          busy_reg  <= 1'b0;
          dwell_reg <= '0;
          if (|ch_valid) begin
            // From IDLE the current sel is itself the first candidate.
            state_reg <= ADVANCE;
            cand_reg  <= sel_reg;
            tries_reg <= '0;
            busy_reg  <= 1'b1;
          end
        end

        ADVANCE: begin
          // disp_reg is left untouched so the old value holds during search.
          if (ch_valid[cand_reg]) begin
            sel_reg   <= cand_reg;
            state_reg <= SHOW;
            busy_reg  <= 1'b0;
            dwell_reg <= '0;
          end else if (tries_reg == TRIES_LAST) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            disp_reg  <= '0;
          end else begin
            cand_reg  <= SW'(next_idx(int'(cand_reg), NUM_CH));
            tries_reg <= tries_reg + SW'(1);
          end
        end

        SHOW: begin
          disp_reg <= (err_flag && phase_reg) ? '0 : nib[sel_reg];
          if (!ch_valid[sel_reg] || adv_req) begin
            state_reg <= ADVANCE;
            cand_reg  <= SW'(next_idx(int'(sel_reg), NUM_CH));
            tries_reg <= '0;
            busy_reg  <= 1'b1;
            dwell_reg <= '0;
          end else if (mode_auto) begin
            dwell_reg <= dwell_reg + DW'(1);
          end else begin
            dwell_reg <= '0;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign disp_value = disp_reg;
  assign sel        = sel_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_led_display_sequencer.sv
module tb_led_display_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] ch_data;
  logic [3:0]  ch_valid;
  logic        btn_next_n;
  logic        mode_auto;
  logic        err_flag;
  logic [3:0]  disp_value;
  logic [1:0]  sel;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] disp;
    logic [1:0] sel;
    logic       busy;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  led_display_sequencer #(
    .NUM_CH         (4),
    .DWELL_CYCLES   (8),
    .DEBOUNCE_CYCLES(4),
    .BLINK_CYCLES   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .btn_next_n(btn_next_n),
    .mode_auto (mode_auto),
    .err_flag  (err_flag),
    .disp_value(disp_value),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs now.
  task automatic check_out();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_empty: observed 0 entries expected >=1");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (disp_value === e.disp) else begin
      errors++;
      $error("FAIL %s disp_value: observed %h expected %h", t, disp_value, e.disp);
    end
    checks++;
    assert (sel === e.sel) else begin
      errors++;
      $error("FAIL %s sel: observed %0d expected %0d", t, sel, e.sel);
    end
    checks++;
    assert (busy === e.busy) else begin
      errors++;
      $error("FAIL %s busy: observed %b expected %b", t, busy, e.busy);
    end
    $display("check %-16s disp=%h sel=%0d busy=%b", t, disp_value, sel, busy);
  endtask

  // Queue the expected outputs, let n falling edges pass, then compare.
  task automatic expect_after(input int n, input string tag,
                              input logic [3:0] d, input logic [1:0] s,
                              input logic b);
    exp_t e;
    e.disp = d;
    e.sel  = s;
    e.busy = b;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (n > 0) cyc(n);
    check_out();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    ch_data    = 16'hDCBA;
    ch_valid   = 4'b0000;
    btn_next_n = 1'b1;
    mode_auto  = 1'b0;
    err_flag   = 1'b0;
    cyc(3);
    expect_after(0, "rst_hold", 4'h0, 2'd0, 1'b0);
    rst_n = 1'b1;
    expect_after(2, "idle", 4'h0, 2'd0, 1'b0);
    expect_after(5, "idle_stay", 4'h0, 2'd0, 1'b0);

    // First valid set: one ADVANCE cycle testing sel=0 itself.
    ch_valid = 4'b1111;
    expect_after(1, "first_adv", 4'h0, 2'd0, 1'b1);
    expect_after(1, "first_show", 4'h0, 2'd0, 1'b0);
    expect_after(1, "first_disp", 4'hA, 2'd0, 1'b0);

    // Auto-scroll: 8 SHOW cycles + 1 ADVANCE per channel.
    mode_auto = 1'b1;
    expect_after(8, "dwell_adv", 4'hA, 2'd0, 1'b1);
    expect_after(2, "auto_ch1", 4'hB, 2'd1, 1'b0);
    expect_after(9, "auto_ch2", 4'hC, 2'd2, 1'b0);
    expect_after(9, "auto_ch3", 4'hD, 2'd3, 1'b0);
    expect_after(9, "auto_wrap", 4'hA, 2'd0, 1'b0);
    mode_auto = 1'b0;
    ch_valid  = 4'b0101;
    cyc(3);

    // Clean press held 6 cycles: candidate 1 rejected, lands on 2.
    btn_next_n = 1'b0;
    cyc(6);
    btn_next_n = 1'b1;
    expect_after(1, "press_busy1", 4'hA, 2'd0, 1'b1);
    expect_after(1, "press_busy2", 4'hA, 2'd0, 1'b1);
    expect_after(1, "press_sel", 4'hA, 2'd2, 1'b0);
    expect_after(1, "press_disp", 4'hC, 2'd2, 1'b0);
    cyc(10);

    // Second press wraps through 3 back to 0.
    btn_next_n = 1'b0;
    cyc(6);
    btn_next_n = 1'b1;
    expect_after(3, "wrap_sel", 4'hC, 2'd0, 1'b0);
    expect_after(1, "wrap_disp", 4'hA, 2'd0, 1'b0);
    cyc(10);

    // Bounce: two 3-cycle lows separated by one high cycle -> no press.
    btn_next_n = 1'b0;
    cyc(3);
    btn_next_n = 1'b1;
    cyc(1);
    btn_next_n = 1'b0;
    cyc(3);
    btn_next_n = 1'b1;
    expect_after(12, "bounce_ignored", 4'hA, 2'd0, 1'b0);

    // Press pulse lands while a search (caused by ch_valid[0] dropping)
    // is running: it must be discarded, leaving sel on channel 1.
    btn_next_n = 1'b0;
    cyc(5);
    ch_valid = 4'b1010;
    cyc(1);
    btn_next_n = 1'b1;
    expect_after(0, "busy_press_adv", 4'hA, 2'd0, 1'b1);
    expect_after(1, "busy_press_sel", 4'hA, 2'd1, 1'b0);
    expect_after(6, "press_ignored", 4'hB, 2'd1, 1'b0);
    cyc(6);

    // Blink overlay on value B, period 3 cycles per phase.
    err_flag = 1'b1;
    expect_after(3, "blink_on1", 4'hB, 2'd1, 1'b0);
    expect_after(1, "blink_off1", 4'h0, 2'd1, 1'b0);
    expect_after(2, "blink_off2", 4'h0, 2'd1, 1'b0);
    expect_after(1, "blink_on2", 4'hB, 2'd1, 1'b0);
    expect_after(3, "blink_off3", 4'h0, 2'd1, 1'b0);
    cyc(2);
    err_flag = 1'b0;
    expect_after(2, "blink_clear", 4'hB, 2'd1, 1'b0);
    expect_after(3, "blink_steady", 4'hB, 2'd1, 1'b0);

    // Displayed channel becomes invalid: re-search 2 (invalid) then 3.
    ch_valid = 4'b1000;
    expect_after(1, "drop_busy", 4'hB, 2'd1, 1'b1);
    expect_after(2, "drop_sel", 4'hB, 2'd3, 1'b0);
    expect_after(1, "drop_disp", 4'hD, 2'd3, 1'b0);

    // Everything invalid: NUM_CH search cycles then IDLE with sel kept.
    ch_valid = 4'b0000;
    expect_after(4, "search_last", 4'hD, 2'd3, 1'b1);
    expect_after(1, "all_invalid", 4'h0, 2'd3, 1'b0);
    expect_after(3, "idle_hold", 4'h0, 2'd3, 1'b0);

    // Leaving IDLE tests sel (3) first, then wraps to 0.
    ch_valid = 4'b0001;
    expect_after(1, "idle_adv", 4'h0, 2'd3, 1'b1);
    expect_after(2, "idle_wrap_sel", 4'h0, 2'd0, 1'b0);
    expect_after(1, "idle_wrap_disp", 4'hA, 2'd0, 1'b0);

    // Reset asserted mid-search clears outputs immediately.
    ch_valid = 4'b1000;
    expect_after(1, "pre_reset_busy", 4'hA, 2'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    expect_after(0, "async_reset", 4'h0, 2'd0, 1'b0);
    ch_valid = 4'b0000;
    cyc(1);
    rst_n = 1'b1;
    expect_after(3, "post_reset", 4'h0, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
